// File: rtl/mips_regfile_dump.sv
// Register-file dump engine: walks ra3 over 0..NREGS-1 and streams each rd3 word out
// through a valid/ready handshake. Define MIPS_DUMP_CKSUM_EN to build the running checksum.
module mips_regfile_dump #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] ra3,
  input  logic [DW-1:0] rd3,
  output logic          busy,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [DW-1:0] dout_data,
  output logic [AW-1:0] dout_idx,
  output logic          dout_last,
  output logic          done,
  output logic [DW-1:0] cksum
);

  typedef enum logic [1:0] {StIdle, StAddr, StHold, StFin} state_e;

  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] oidx_q, oidx_d;
  logic          last_q, last_d;
  logic          valid_q, valid_d;
  logic          start_scan, accept;

  assign start_scan = (state_q == StIdle) && start && !abort;
  // abort outranks a same-cycle handshake, so an aborted word is never counted
  assign accept     = (state_q == StHold) && valid_q && dout_ready && !abort;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    oidx_d  = oidx_q;
    last_d  = last_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (start_scan) begin
          state_d = StAddr;
          idx_d   = '0;
        end
      end
      StAddr: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          data_d  = rd3;
          oidx_d  = idx_q;
          last_d  = (idx_q == LastIdx);
          valid_d = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (abort) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end else if (accept) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StAddr;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      data_q  <= '0;
      oidx_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      oidx_q  <= oidx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

`ifdef MIPS_DUMP_CKSUM_EN
  logic [DW-1:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (start_scan) begin
      cksum_d = '0;
    end else if (accept) begin
      cksum_d = cksum_q + data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

  // ra3 keeps pointing at the current register through HOLD so a stall is harmless
  assign ra3        = (state_q == StIdle) ? '0 : idx_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StFin);
  assign dout_valid = valid_q;
  assign dout_data  = data_q;
  assign dout_idx   = oidx_q;
  assign dout_last  = last_q;

endmodule
